adv7511_iic_master: RTL and testbench
=====================================

Name: adv7511_iic_master

Overview:
Byte-level I2C master directly downstream of the ADV7511 configuration sequencer. It takes one-cycle start requests carrying a register address, a data byte, a read/write flag and a bus-switch flag. It runs the matching I2C transaction on open-drain SCL/SDA and returns finish, no-ack and read-data strobes. The sequencer consumes these to advance its register list and poll HPD.

Parameters:
CLK_DIV, 186, i_clk cycles per SCL quarter-period (74.25 MHz gives ~99.8 kHz SCL); must be ≥2
SLAVE_ADDR, 7'h39, ADV7511 7-bit address (8'h72 write)
SWITCH_ADDR, 7'h74, 7-bit address of the 1-to-8 bus switch
SWITCH_CHAN, 8'h20, control byte written to the switch to select the HDMI channel

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_start  in  1  one-cycle transaction request
i_wr_rd_en  in  1  0 = register write, 1 = register read
i_iic_main  in  1  1 = switch-select write (i_wr_rd_en, i_addr, i_din ignored)
i_addr  in  8  ADV7511 register address
i_din  in  8  write data
i_sda  in  1  SDA pad input (asynchronous)
o_scl_oe  out  1  1 = drive SCL low, 0 = release
o_sda_oe  out  1  1 = drive SDA low, 0 = release
o_busy  out  1  transaction in progress
o_finish  out  1  one-cycle pulse at transaction end
o_no_ack  out  1  valid with o_finish; held until next accepted start
o_dout_en  out  1  one-cycle read-data strobe
o_dout  out  8  read byte; held until next read completes

Behaviour:
- Reset: all outputs 0, so SCL and SDA are released high. FSM goes to IDLE. Reset mid-transaction releases both lines on the next cycle and produces no o_finish.
- Quarter tick: a counter 0..CLK_DIV-1 pulses one tick per wrap. It runs only when not IDLE and is cleared on start accept.
- Start accept: i_start is accepted only in IDLE. Inputs are latched, o_busy=1 and o_no_ack is cleared on the next cycle. i_start while busy is ignored.
- Bit timing uses 4 quarters. q0: SCL low, update SDA. q1: release SCL. q2: SCL high, sample synced SDA. q3: drive SCL low.
- i_sda passes through a 2-flop synchronizer. Clock stretching is not supported.
- START (4 quarters): SDA high/SCL high, then SDA low, then SCL low.
- Repeated START (4 quarters): release SDA, release SCL, SDA low, SCL low.
- STOP (4 quarters): SDA low, release SCL, release SDA.
- Transaction types:
  - Write: S, SLAVE_ADDR+W, A, i_addr, A, i_din, A, P → 116 quarters.
  - Read: S, SLAVE_ADDR+W, A, i_addr, A, Sr, SLAVE_ADDR+R, A, 8 data bits, master NACK, P → 156 quarters.
  - Switch (i_iic_main=1): S, SWITCH_ADDR+W, A, SWITCH_CHAN, A, P → 80 quarters.
- Bit order is MSB first. During slave ACK and read data bits, o_sda_oe=0.
- FSM states: IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_NACK, STOP, DONE. A 3-bit bit counter and a 2-bit byte index are kept.
- RX_ACK sampling SDA=1 (NACK) skips all remaining bytes and goes to STOP, then DONE with o_no_ack=1.
- RX_BYTE complete: o_dout updated and o_dout_en pulsed for one cycle at the end of the 8th bit's q3, before TX_NACK.
- DONE lasts one cycle: o_finish=1, then o_busy=0 and IDLE. A new i_start in the DONE cycle is ignored. One in the following cycle is accepted.
- o_dout_en and o_finish never assert in the same cycle.

Decomposition:
- Package adv7511_iic_pkg holds:
  - FSM state encoding
  - quarter-phase constants Q0..Q3
  - byte-count constants: WR_BYTES=3, RD_WR_BYTES=2, SW_BYTES=2
  - R/W bit constants
- Sub-module iic_quarter_tick: parameter CLK_DIV; inputs i_clk, i_rst, i_en; outputs o_tick, o_phase[1:0].

Test Plan:
- Write, CLK_DIV=4, i_addr=8'h41, i_din=8'h10, slave model ACKs all → bus shows bytes 72,41,10 with START/STOP; o_finish 1 pulse 464±2 cycles after start; o_no_ack=0.
- Read, i_addr=8'h42, slave returns 8'h40 → bytes 72,42, Sr, 73; o_dout=8'h40 with one o_dout_en pulse; master NACKs the data byte; o_finish follows with o_no_ack=0.
- Switch, i_iic_main=1, i_addr=8'hFF → bytes E8,20 then STOP; i_addr does not appear on the bus; finish after 320±2 cycles.
- Slave NACKs the address byte → STOP issued right after the ACK bit; o_finish with o_no_ack=1; no o_dout_en pulse.
- Second i_start mid-transaction, and i_start in the DONE cycle → both ignored; exactly one o_finish per accepted start.
- i_rst asserted during the 2nd byte → next cycle o_scl_oe=0, o_sda_oe=0, o_busy=0, no o_finish; a following write completes normally.

Source files
------------

// File: rtl/adv7511_iic_pkg.sv
// adv7511_iic_pkg: shared FSM encoding and constants for the ADV7511 I2C master.
package adv7511_iic_pkg;
  typedef enum logic [3:0] {IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_NACK, STOP, DONE} state_e;
  localparam logic [1:0] Q0 = 2'd0, Q1 = 2'd1, Q2 = 2'd2, Q3 = 2'd3;
  localparam logic [1:0] WR_BYTES = 2'd3, RD_WR_BYTES = 2'd2, SW_BYTES = 2'd2;
  localparam logic RW_WRITE = 1'b0, RW_READ = 1'b1;
endpackage

// File: rtl/adv7511_iic_master_iic_quarter_tick.sv
// iic_quarter_tick: divides i_clk into SCL quarter ticks and tracks the quarter phase.
module iic_quarter_tick #(
  parameter int CLK_DIV = 186
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  output logic       o_tick,
  output logic [1:0] o_phase
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] cnt_q;
  logic [1:0] phase_q;
  assign o_tick = i_en && cnt_q == W'(CLK_DIV - 1);
  assign o_phase = phase_q;
  always_ff @(posedge i_clk)
    if (i_rst || !i_en) begin
      cnt_q <= '0;
      phase_q <= '0;
    end else begin
      cnt_q <= o_tick ? '0 : cnt_q + 1'b1;
      phase_q <= phase_q + 2'(o_tick);
    end
endmodule

// File: rtl/adv7511_iic_master.sv
// adv7511_iic_master: byte-level I2C master running ADV7511 register writes/reads and bus-switch selects.
module adv7511_iic_master
  import adv7511_iic_pkg::*;
#(
  parameter int          CLK_DIV     = 186,
  parameter logic [6:0]  SLAVE_ADDR  = 7'h39,
  parameter logic [6:0]  SWITCH_ADDR = 7'h74,
  parameter logic [7:0]  SWITCH_CHAN = 8'h20
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_wr_rd_en,
  input  logic       i_iic_main,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_din,
  input  logic       i_sda,
  output logic       o_scl_oe,
  output logic       o_sda_oe,
  output logic       o_busy,
  output logic       o_finish,
  output logic       o_no_ack,
  output logic       o_dout_en,
  output logic [7:0] o_dout
);
  state_e state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] idx_q, idx_d, phase, last_idx;
  logic [1:0] sync_q;
  logic [7:0] addr_q, din_q, rx_q, dout_q, tx_byte;
  logic main_q, rd_q, no_ack_q, dout_en_q, tick, slot_end, sample, scl_low;
  iic_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(state_q != IDLE), .o_tick(tick), .o_phase(phase)
  );
  assign slot_end = tick && phase == Q3;
  assign sample = tick && phase == Q2;
  assign scl_low = phase == Q0 || phase == Q3;
  assign last_idx = main_q ? SW_BYTES - 2'd1 : WR_BYTES - 2'd1;
  // byte 2 is the write data, or the read-direction address after the repeated START
  assign tx_byte = idx_q == 2'd0 ? {main_q ? SWITCH_ADDR : SLAVE_ADDR, RW_WRITE} :
                   idx_q == 2'd1 ? (main_q ? SWITCH_CHAN : addr_q) :
                   rd_q ? {SLAVE_ADDR, RW_READ} : din_q;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state_q <= IDLE;
      bit_q <= '0;
      idx_q <= '0;
      sync_q <= 2'b11;
      {main_q, rd_q, addr_q, din_q, rx_q} <= '0;
      {no_ack_q, dout_en_q, dout_q} <= '0;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      idx_q <= idx_d;
      sync_q <= {sync_q[0], i_sda};
      if (state_q == IDLE && i_start) begin
        main_q <= i_iic_main;
        rd_q <= i_wr_rd_en & ~i_iic_main;
        addr_q <= i_addr;
        din_q <= i_din;
        no_ack_q <= 1'b0;
      end
      if (sample && (state_q == RX_ACK || state_q == RX_BYTE)) rx_q <= {rx_q[6:0], sync_q[1]};
      if (slot_end && state_q == RX_ACK && rx_q[0]) no_ack_q <= 1'b1;
      dout_en_q <= slot_end && state_q == RX_BYTE && bit_q == 3'd0;
      if (slot_end && state_q == RX_BYTE && bit_q == 3'd0) dout_q <= rx_q;
    end
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: state_d = i_start ? START : IDLE;
      START: if (slot_end) begin
        state_d = TX_BYTE;
        bit_d = 3'd7;
        idx_d = 2'd0;
      end
      TX_BYTE: if (slot_end) begin
        state_d = bit_q == 3'd0 ? RX_ACK : TX_BYTE;
        bit_d = bit_q - 3'd1;
      end
      RX_ACK: if (slot_end) begin
        idx_d = idx_q + 2'd1;
        state_d = rx_q[0] ? STOP :
                  rd_q && idx_q == RD_WR_BYTES - 2'd1 ? RESTART :
                  rd_q && idx_q == RD_WR_BYTES ? RX_BYTE :
                  idx_q == last_idx ? STOP : TX_BYTE;
      end
      RESTART: state_d = slot_end ? TX_BYTE : RESTART;
      RX_BYTE: if (slot_end) begin
        state_d = bit_q == 3'd0 ? TX_NACK : RX_BYTE;
        bit_d = bit_q - 3'd1;
      end
      TX_NACK: state_d = slot_end ? STOP : TX_NACK;
      STOP: state_d = slot_end ? DONE : STOP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    o_scl_oe = 1'b0;
    o_sda_oe = 1'b0;
    case (state_q)
      START: begin
        o_scl_oe = phase == Q3;
        o_sda_oe = phase[1];
      end
      TX_BYTE: begin
        o_scl_oe = scl_low;
        o_sda_oe = ~tx_byte[bit_q];
      end
      RX_ACK, RX_BYTE, TX_NACK: o_scl_oe = scl_low;
      RESTART: begin
        o_scl_oe = scl_low;
        o_sda_oe = phase[1];
      end
      STOP: begin
        o_scl_oe = phase == Q0;
        o_sda_oe = phase != Q3;
      end
      default: ;
    endcase
  end
  assign o_busy = state_q != IDLE;
  assign o_finish = state_q == DONE;
  assign o_no_ack = no_ack_q;
  assign o_dout_en = dout_en_q;
  assign o_dout = dout_q;
endmodule

// File: tb/tb_adv7511_iic_master.sv
// tb_adv7511_iic_master: drives transactions against an I2C slave model and scoreboards the bus events.
module tb_adv7511_iic_master;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, wr_rd_en = 1'b0, iic_main = 1'b0;
  logic [7:0] addr = '0, din = '0, dout;
  logic scl_oe, sda_oe, busy, finish, no_ack, dout_en, sda_line, scl_line;
  logic s_drv = 1'b0;
  int nvec = 0, nerr = 0, fin_cnt = 0, den_cnt = 0, overlap_cnt = 0;
  // bus events: 0xx byte, 100 START, 101 STOP, 102 master NACK, 103 master ACK
  logic [8:0] exp_q[$];
  logic sb_off = 1'b0, nack_addr = 1'b0;
  logic [7:0] rd_data = 8'h00;

  always #5 clk = ~clk;
  assign sda_line = !(sda_oe || s_drv);
  assign scl_line = !scl_oe;

  adv7511_iic_master #(.CLK_DIV(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_wr_rd_en(wr_rd_en), .i_iic_main(iic_main),
    .i_addr(addr), .i_din(din), .i_sda(sda_line), .o_scl_oe(scl_oe), .o_sda_oe(sda_oe),
    .o_busy(busy), .o_finish(finish), .o_no_ack(no_ack), .o_dout_en(dout_en), .o_dout(dout)
  );

  // slave model and bus monitor, sampling on the inactive clock edge
  logic prev_scl = 1'b1, prev_sda = 1'b1, tx_mode = 1'b0, first = 1'b0, rd_pend = 1'b0;
  int bitn = -1;
  logic [7:0] sh = '0;
  always @(negedge clk) begin
    logic sc, sd, has_ev;
    logic [8:0] ev, e;
    sc = scl_line;
    sd = sda_line;
    has_ev = 1'b0;
    ev = '0;
    fin_cnt += int'(finish);
    den_cnt += int'(dout_en);
    if (finish && dout_en) overlap_cnt++;
    if (rst) begin
      s_drv = 1'b0;
      bitn = -1;
      tx_mode = 1'b0;
      rd_pend = 1'b0;
    end else begin
      if (sc && prev_scl && prev_sda && !sd) begin
        has_ev = 1'b1; ev = 9'h100; bitn = -1; tx_mode = 1'b0; first = 1'b1; rd_pend = 1'b0;
      end else if (sc && prev_scl && !prev_sda && sd) begin
        has_ev = 1'b1; ev = 9'h101;
      end
      if (!prev_scl && sc) begin
        if (bitn >= 0 && bitn < 8) sh = {sh[6:0], sd};
        else if (bitn == 8 && tx_mode) begin
          has_ev = 1'b1; ev = sd ? 9'h102 : 9'h103;
          if (sd) tx_mode = 1'b0;
        end
      end
      if (prev_scl && !sc) begin
        bitn = bitn == 8 ? 0 : bitn + 1;
        if (bitn == 8) begin
          has_ev = 1'b1; ev = {1'b0, sh};
          s_drv = tx_mode ? 1'b0 : !(first && nack_addr);
          rd_pend = first && sh[0] && !nack_addr;
          first = 1'b0;
        end else if (bitn == 0) begin
          s_drv = 1'b0;
          if (rd_pend) begin
            tx_mode = 1'b1; rd_pend = 1'b0; s_drv = !rd_data[7];
          end
        end else if (tx_mode) s_drv = !rd_data[3'(7 - bitn)];
      end
      if (has_ev && !sb_off) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL bus_event: got %h, none expected", ev);
        end else begin
          e = exp_q.pop_front();
          if (ev !== e) begin
            nerr++;
            $display("FAIL bus_event: got %h, expected %h", ev, e);
          end
        end
      end
    end
    prev_scl = sc;
    prev_sda = sd;
  end

  task automatic push_txn(input logic m, input logic r, input logic [7:0] a, input logic [7:0] d, input logic nk);
    exp_q.push_back(9'h100);
    exp_q.push_back(m ? 9'h0E8 : 9'h072);
    if (nk) begin
      exp_q.push_back(9'h101);
      return;
    end
    exp_q.push_back(m ? 9'h020 : {1'b0, a});
    if (!m && r) begin
      exp_q.push_back(9'h100);
      exp_q.push_back(9'h073);
      exp_q.push_back({1'b0, rd_data});
      exp_q.push_back(9'h102);
    end else if (!m) exp_q.push_back({1'b0, d});
    exp_q.push_back(9'h101);
  endtask

  task automatic run_txn(input logic m, input logic r, input logic [7:0] a, input logic [7:0] d, output int cyc);
    @(negedge clk);
    iic_main = m; wr_rd_en = r; addr = a; din = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!finish && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    nvec++;
    if ({scl_oe, sda_oe, busy, finish, no_ack, dout_en, dout} !== 14'h0) begin
      nerr++;
      $display("FAIL reset_outputs: got %h, expected 0", {scl_oe, sda_oe, busy, finish, no_ack, dout_en, dout});
    end
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if (busy !== 1'b0 || scl_line !== 1'b1 || sda_line !== 1'b1) begin
      nerr++;
      $display("FAIL idle_lines: busy=%b scl=%b sda=%b, expected 0 1 1", busy, scl_line, sda_line);
    end
  endtask

  task automatic test_write;
    int cyc, f0;
    f0 = fin_cnt;
    push_txn(1'b0, 1'b0, 8'h41, 8'h10, 1'b0);
    run_txn(1'b0, 1'b0, 8'h41, 8'h10, cyc);
    nvec++;
    if (cyc < 462 || cyc > 466) begin nerr++; $display("FAIL write_latency: got %0d, expected 464+-2", cyc); end
    nvec++;
    if (no_ack !== 1'b0) begin nerr++; $display("FAIL write_no_ack: got %b, expected 0", no_ack); end
    @(negedge clk);
    nvec++;
    if (fin_cnt - f0 != 1 || busy !== 1'b0) begin nerr++; $display("FAIL write_finish: pulses %0d busy %b, expected 1 0", fin_cnt - f0, busy); end
    nvec++;
    if (exp_q.size() != 0) begin nerr++; $display("FAIL write_events: %0d missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_read;
    int cyc, d0;
    d0 = den_cnt;
    rd_data = 8'h40;
    push_txn(1'b0, 1'b1, 8'h42, 8'h00, 1'b0);
    run_txn(1'b0, 1'b1, 8'h42, 8'h00, cyc);
    nvec++;
    if (cyc < 622 || cyc > 626) begin nerr++; $display("FAIL read_latency: got %0d, expected 624+-2", cyc); end
    nvec++;
    if (dout !== 8'h40 || den_cnt - d0 != 1) begin nerr++; $display("FAIL read_data: got %h x%0d, expected 40 x1", dout, den_cnt - d0); end
    nvec++;
    if (no_ack !== 1'b0) begin nerr++; $display("FAIL read_no_ack: got %b, expected 0", no_ack); end
    nvec++;
    if (exp_q.size() != 0) begin nerr++; $display("FAIL read_events: %0d missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_switch;
    int cyc;
    push_txn(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);
    run_txn(1'b1, 1'b1, 8'hFF, 8'hFF, cyc);
    nvec++;
    if (cyc < 318 || cyc > 322) begin nerr++; $display("FAIL switch_latency: got %0d, expected 320+-2", cyc); end
    nvec++;
    if (exp_q.size() != 0) begin nerr++; $display("FAIL switch_events: %0d missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_nack;
    int cyc, d0;
    d0 = den_cnt;
    nack_addr = 1'b1;
    push_txn(1'b0, 1'b1, 8'h42, 8'h00, 1'b1);
    run_txn(1'b0, 1'b1, 8'h42, 8'h00, cyc);
    nack_addr = 1'b0;
    nvec++;
    if (no_ack !== 1'b1) begin nerr++; $display("FAIL nack_flag: got %b, expected 1", no_ack); end
    nvec++;
    if (cyc < 174 || cyc > 178) begin nerr++; $display("FAIL nack_latency: got %0d, expected 176+-2", cyc); end
    repeat (4) @(negedge clk);
    nvec++;
    if (den_cnt != d0 || exp_q.size() != 0) begin nerr++; $display("FAIL nack_events: dout_en x%0d missing %0d, expected 0 0", den_cnt - d0, exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    int n, f0;
    f0 = fin_cnt;
    push_txn(1'b0, 1'b0, 8'h55, 8'hAA, 1'b0);
    @(negedge clk);
    iic_main = 1'b0; wr_rd_en = 1'b0; addr = 8'h55; din = 8'hAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nvec++;
    if (busy !== 1'b1 || no_ack !== 1'b0) begin nerr++; $display("FAIL accept: busy %b no_ack %b, expected 1 0", busy, no_ack); end
    repeat (100) @(negedge clk);
    iic_main = 1'b1; addr = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!finish && n < 3000) begin @(negedge clk); n++; end
    start = 1'b1;
    @(negedge clk);
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL done_start_ignored: busy %b, expected 0", busy); end
    push_txn(1'b1, 1'b0, 8'h11, 8'h00, 1'b0);
    @(negedge clk);
    start = 1'b0;
    nvec++;
    if (busy !== 1'b1) begin nerr++; $display("FAIL next_cycle_accept: busy %b, expected 1", busy); end
    n = 0;
    while (!finish && n < 3000) begin @(negedge clk); n++; end
    @(negedge clk);
    nvec++;
    if (fin_cnt - f0 != 2 || exp_q.size() != 0) begin nerr++; $display("FAIL b2b_finish: pulses %0d missing %0d, expected 2 0", fin_cnt - f0, exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    int f0, cyc;
    sb_off = 1'b1;
    @(negedge clk);
    iic_main = 1'b0; wr_rd_en = 1'b0; addr = 8'h41; din = 8'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    f0 = fin_cnt;
    rst = 1'b1;
    @(negedge clk);
    nvec++;
    if ({scl_oe, sda_oe, busy} !== 3'b000) begin nerr++; $display("FAIL mid_reset: scl/sda/busy %b, expected 000", {scl_oe, sda_oe, busy}); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    nvec++;
    if (fin_cnt != f0 || busy !== 1'b0) begin nerr++; $display("FAIL mid_reset_finish: pulses %0d busy %b, expected 0 0", fin_cnt - f0, busy); end
    exp_q.delete();
    sb_off = 1'b0;
    push_txn(1'b0, 1'b0, 8'h41, 8'h10, 1'b0);
    run_txn(1'b0, 1'b0, 8'h41, 8'h10, cyc);
    nvec++;
    if (cyc < 462 || cyc > 466 || exp_q.size() != 0) begin nerr++; $display("FAIL post_reset_write: %0d cycles missing %0d, expected 464 0", cyc, exp_q.size()); end
  endtask

  task automatic test_random;
    int cyc;
    logic r;
    logic [7:0] a, d;
    for (int i = 0; i < 4; i++) begin
      r = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      d = 8'($urandom);
      rd_data = 8'($urandom);
      push_txn(1'b0, r, a, d, 1'b0);
      run_txn(1'b0, r, a, d, cyc);
      nvec++;
      if (exp_q.size() != 0 || no_ack !== 1'b0) begin nerr++; $display("FAIL rand_txn %0d: missing %0d no_ack %b, expected 0 0", i, exp_q.size(), no_ack); end
      if (r) begin
        nvec++;
        if (dout !== rd_data) begin nerr++; $display("FAIL rand_read %0d: got %h, expected %h", i, dout, rd_data); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_switch();
    test_nack();
    test_back_to_back();
    test_reset_mid();
    test_random();
    nvec++;
    if (overlap_cnt != 0) begin nerr++; $display("FAIL finish_dout_en_overlap: got %0d, expected 0", overlap_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
